dft_sample_scheduler: RTL and testbench

Paces incoming audio samples into the DFT core so that each `sampleReady` strobe gets the core's full per-sample processing window. The block buffers producer samples in a small FIFO and issues one sample per window. It pulses `binsValid` once every `UPDATE` processed samples, which tells downstream consumers that `outBins` holds a fresh, settled snapshot. It sits between the sample source (ADC/I2S front end) and the `DFT` instance.

---
 rtl/dft_sample_scheduler_if.sv | 31 +++
 rtl/dft_sample_scheduler.sv | 143 ++++++++++++++
 tb/tb_dft_sample_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dft_sample_scheduler_if.sv
// Streaming bundle between the sample producer, the scheduler and the DFT core.
// The scheduler is the slave: it accepts producer samples and drives the
// paced sample stream plus the bin-snapshot pulse toward the DFT side.
interface dft_sample_scheduler_if #(
  parameter int W = 16
);
  logic signed [W-1:0] inSample;
  logic                inValid;
  logic                inReady;
  logic signed [W-1:0] sampleOut;
  logic                sampleReady;
  logic                binsValid;

  modport master (
    output inSample,
    output inValid,
    input  inReady,
    input  sampleOut,
    input  sampleReady,
    input  binsValid
  );

  modport slave (
    input  inSample,
    input  inValid,
    output inReady,
    output sampleOut,
    output sampleReady,
    output binsValid
  );
endinterface

// File: rtl/dft_sample_scheduler.sv
// DFT sample scheduler: buffers producer samples in a small FIFO and hands
// them to the DFT core one at a time, leaving GAP idle cycles after every
// strobe so the core finishes its per-sample work. Every UPDATE strobes it
// pulses binsValid in the last idle cycle, when the bins have settled.
module dft_sample_scheduler #(
  parameter int W      = 16,
  parameter int DEPTH  = 8,
  parameter int GAP    = 250,
  parameter int UPDATE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  dft_sample_scheduler_if.slave  bus,
  input  logic                   enable,
  input  logic                   clrOvf,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fillLevel,
  output logic [31:0]            samplesIssued
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [31:0] UPDATE32 = 32'(UPDATE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] headPtr;
  logic [CW-1:0] waitCnt;
  logic          full;
  logic          push;
  logic          pop;
  logic          haveNext;
  logic          lastWait;
  logic          issueNow;
  logic          binsHit;

  assign full        = (fillLevel == LW'(DEPTH));
  assign bus.inReady = !full;
  assign push        = bus.inValid && !full;
  assign pop         = (state == ISSUE);

  // Issue decision and the sample it would pick; with GAP of zero a back-to-back
  // issue happens while the current head is still being popped, so look one ahead.
  always_comb begin
    haveNext = (state == ISSUE) ? (fillLevel > LW'(1)) : (fillLevel != '0);
    lastWait = (state == WAIT) && (waitCnt == CW'(1));
    issueNow = enable && haveNext &&
               ((state == IDLE) || lastWait || ((state == ISSUE) && (GAP == 0)));
    headPtr  = (state == ISSUE) ? rdPtr + AW'(1) : rdPtr;
    binsHit  = 1'b0;
    if (GAP == 0)
      binsHit = issueNow && (((samplesIssued + 32'd1) % UPDATE32) == 32'd0);
    else if (GAP == 1)
      binsHit = (state == ISSUE) && ((samplesIssued % UPDATE32) == 32'd0);
    else
      binsHit = (state == WAIT) && (waitCnt == CW'(2)) &&
                ((samplesIssued % UPDATE32) == 32'd0);
  end

  // FIFO storage; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= bus.inSample;
  end

  // FIFO pointers and occupancy; a push and pop in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fillLevel <= '0;
    end else begin
      if (push)
        wrPtr <= wrPtr + AW'(1);
      if (pop)
        rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   fillLevel <= fillLevel + LW'(1);
        2'b01:   fillLevel <= fillLevel - LW'(1);
        default: fillLevel <= fillLevel;
      endcase
    end
  end

  // Sticky overflow flag; a rejected offer wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow <= 1'b0;
    else if (bus.inValid && full)
      overflow <= 1'b1;
    else if (clrOvf)
      overflow <= 1'b0;
  end

  // Pacing FSM with registered strobe, sample, snapshot pulse and issue count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      waitCnt        <= '0;
      bus.sampleReady <= 1'b0;
      bus.binsValid  <= 1'b0;
      bus.sampleOut  <= '0;
      samplesIssued  <= '0;
    end else begin
      bus.sampleReady <= issueNow;
      bus.binsValid   <= binsHit;
      if (issueNow) begin
        bus.sampleOut <= mem[headPtr];
        samplesIssued <= samplesIssued + 32'd1;
      end
      case (state)
        IDLE: begin
          if (issueNow)
            state <= ISSUE;
        end
        ISSUE: begin
          if (GAP == 0) begin
            state <= issueNow ? ISSUE : IDLE;
          end else begin
            waitCnt <= CW'(GAP);
            state   <= WAIT;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - CW'(1);
          if (lastWait)
            state <= issueNow ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dft_sample_scheduler.sv
// Directed bench for dft_sample_scheduler at default parameters
// (W=16, DEPTH=8, GAP=250, UPDATE=64).
module tb_dft_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clrOvf = 1'b0;
  logic        overflow;
  logic [3:0]  fillLevel;
  logic [31:0] samplesIssued;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [15:0] strobeData[$];
  int          strobeCyc[$];
  int          binsCyc[$];

  dft_sample_scheduler_if #(.W(16)) bus ();

  dft_sample_scheduler #(
    .W(16), .DEPTH(8), .GAP(250), .UPDATE(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .enable(enable),
    .clrOvf(clrOvf),
    .overflow(overflow),
    .fillLevel(fillLevel),
    .samplesIssued(samplesIssued)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Edge counter used to timestamp strobes and snapshot pulses.
  always @(posedge clk) cycle = cycle + 1;

  // Record every strobe and snapshot pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus.sampleReady) begin
      strobeData.push_back(bus.sampleOut);
      strobeCyc.push_back(cycle);
    end
    if (bus.binsValid)
      binsCyc.push_back(cycle);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d);
    bus.inValid  = v;
    bus.inSample = d;
    tick(1);
    bus.inValid  = 1'b0;
  endtask

  task automatic waitUntil(input int target);
    while (cycle < target) tick(1);
  endtask

  task automatic clearLogs();
    strobeData.delete();
    strobeCyc.delete();
    binsCyc.delete();
  endtask

  task automatic doReset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    clearLogs();
  endtask

  initial begin
    int t;
    int k;
    int bad;
    bus.inValid  = 1'b0;
    bus.inSample = '0;

    // Reset values while reset is held
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_sampleReady", 32'(bus.sampleReady), 32'd0);
    checkOutput("rst_binsValid", 32'(bus.binsValid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_sampleOut", 32'(bus.sampleOut), 32'd0);
    checkOutput("rst_fillLevel", 32'(fillLevel), 32'd0);
    checkOutput("rst_samplesIssued", samplesIssued, 32'd0);
    checkOutput("rst_inReady", 32'(bus.inReady), 32'd1);
    @(posedge clk); #1;
    tick(2);
    rst = 1'b1;
    clearLogs();
    tick(2);

    // Three samples paced 251 cycles apart, first one a cycle after acceptance
    enable = 1'b1;
    applyStimulus(1'b1, 16'h0001);
    t = cycle;
    checkOutput("t1_noEarlyStrobe", 32'(bus.sampleReady), 32'd0);
    applyStimulus(1'b1, 16'hFFFF);
    checkOutput("t1_latencyStrobe", 32'(bus.sampleReady), 32'd1);
    checkOutput("t1_latencyData", 32'(bus.sampleOut), 32'h0000_0001);
    applyStimulus(1'b1, 16'h7FFF);
    checkOutput("t1_strobeWidth", 32'(bus.sampleReady), 32'd0);
    tick(800);
    checkOutput("t1_strobeCount", 32'(strobeData.size()), 32'd3);
    if (strobeData.size() >= 3) begin
      checkOutput("t1_data0", 32'(strobeData[0]), 32'h0001);
      checkOutput("t1_data1", 32'(strobeData[1]), 32'hFFFF);
      checkOutput("t1_data2", 32'(strobeData[2]), 32'h7FFF);
      checkOutput("t1_cyc0", 32'(strobeCyc[0]), 32'(t + 1));
      checkOutput("t1_cyc1", 32'(strobeCyc[1]), 32'(t + 252));
      checkOutput("t1_cyc2", 32'(strobeCyc[2]), 32'(t + 503));
    end
    checkOutput("t1_samplesIssued", samplesIssued, 32'd3);
    checkOutput("t1_fillLevel", 32'(fillLevel), 32'd0);
    checkOutput("t1_holdData", 32'(bus.sampleOut), 32'h7FFF);
    checkOutput("t1_noBins", 32'(binsCyc.size()), 32'd0);

    // Fill with enable low, overflow, clear, then drain in order
    enable = 1'b0;
    clearLogs();
    for (int i = 0; i < 10; i++) begin
      if (i == 9) clrOvf = 1'b1;
      applyStimulus(1'b1, 16'(16'h0100 + i));
      clrOvf = 1'b0;
      if (i == 7) begin
        checkOutput("t2_fullLevel", 32'(fillLevel), 32'd8);
        checkOutput("t2_fullReady", 32'(bus.inReady), 32'd0);
        checkOutput("t2_noOvfYet", 32'(overflow), 32'd0);
      end
      if (i == 8) checkOutput("t2_ovfSet", 32'(overflow), 32'd1);
    end
    checkOutput("t2_setWinsOverClear", 32'(overflow), 32'd1);
    checkOutput("t2_levelAfterOvf", 32'(fillLevel), 32'd8);
    clrOvf = 1'b1;
    tick(1);
    clrOvf = 1'b0;
    checkOutput("t2_ovfCleared", 32'(overflow), 32'd0);
    enable = 1'b1;
    k = cycle;
    tick(2100);
    checkOutput("t2_strobeCount", 32'(strobeData.size()), 32'd8);
    if (strobeData.size() >= 8) begin
      checkOutput("t2_firstCyc", 32'(strobeCyc[0]), 32'(k + 1));
      bad = 0;
      for (int i = 0; i < 8; i++) begin
        if (strobeData[i] !== 16'(16'h0100 + i)) bad++;
        if (i > 0 && (strobeCyc[i] - strobeCyc[i-1]) != 251) bad++;
      end
      checkOutput("t2_orderAndSpacing", 32'(bad), 32'd0);
    end
    checkOutput("t2_samplesIssued", samplesIssued, 32'd11);
    checkOutput("t2_drained", 32'(fillLevel), 32'd0);
    checkOutput("t2_readyAgain", 32'(bus.inReady), 32'd1);

    // 128 samples: binsValid exactly after strobes #64 and #128
    doReset();
    enable = 1'b1;
    for (int i = 0; i < 128; i++) begin
      int guard;
      guard = 0;
      while (!bus.inReady && guard < 400) begin
        tick(1);
        guard++;
      end
      if (guard >= 400) checkOutput("t3_inReadyTimeout", 32'(bus.inReady), 32'd1);
      applyStimulus(1'b1, 16'(16'h0A00 + i));
    end
    tick(9 * 251 + 100);
    checkOutput("t3_strobeCount", 32'(strobeData.size()), 32'd128);
    checkOutput("t3_binsCount", 32'(binsCyc.size()), 32'd2);
    if (strobeData.size() >= 128) begin
      bad = 0;
      for (int i = 0; i < 128; i++) begin
        if (strobeData[i] !== 16'(16'h0A00 + i)) bad++;
        if (i > 0 && (strobeCyc[i] - strobeCyc[i-1]) != 251) bad++;
      end
      checkOutput("t3_orderAndSpacing", 32'(bad), 32'd0);
      if (binsCyc.size() >= 2) begin
        checkOutput("t3_bins0Pos", 32'(binsCyc[0]), 32'(strobeCyc[63] + 250));
        checkOutput("t3_bins1Pos", 32'(binsCyc[1]), 32'(strobeCyc[127] + 250));
      end
    end
    checkOutput("t3_samplesIssued", samplesIssued, 32'd128);

    // Enable dropped mid-WAIT with two queued, then re-raised
    doReset();
    enable = 1'b1;
    applyStimulus(1'b1, 16'h1111);
    t = cycle;
    applyStimulus(1'b1, 16'h2222);
    applyStimulus(1'b1, 16'h3333);
    waitUntil(t + 101);
    enable = 1'b0;
    waitUntil(t + 500);
    checkOutput("t4_noMoreStrobes", 32'(strobeData.size()), 32'd1);
    checkOutput("t4_queued", 32'(fillLevel), 32'd2);
    enable = 1'b1;
    k = cycle;
    tick(1);
    checkOutput("t4_resumeStrobe", 32'(bus.sampleReady), 32'd1);
    checkOutput("t4_resumeData", 32'(bus.sampleOut), 32'h2222);
    tick(600);
    checkOutput("t4_strobeCount", 32'(strobeData.size()), 32'd3);
    if (strobeData.size() >= 3) begin
      checkOutput("t4_resumeCyc", 32'(strobeCyc[1]), 32'(k + 1));
      checkOutput("t4_lastData", 32'(strobeData[2]), 32'h3333);
    end

    // Reset mid-WAIT with four queued
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h5000 + i));
    tick(50);
    checkOutput("t5_preQueued", 32'(fillLevel), 32'd4);
    rst = 1'b0;
    #2;
    checkOutput("t5_sampleReady", 32'(bus.sampleReady), 32'd0);
    checkOutput("t5_binsValid", 32'(bus.binsValid), 32'd0);
    checkOutput("t5_overflow", 32'(overflow), 32'd0);
    checkOutput("t5_sampleOut", 32'(bus.sampleOut), 32'd0);
    checkOutput("t5_fillLevel", 32'(fillLevel), 32'd0);
    checkOutput("t5_samplesIssued", samplesIssued, 32'd0);
    checkOutput("t5_inReady", 32'(bus.inReady), 32'd1);
    clearLogs();
    tick(2);
    rst = 1'b1;
    tick(600);
    checkOutput("t5_noStrobeAfterReset", 32'(strobeData.size()), 32'd0);
    applyStimulus(1'b1, 16'h5A5A);
    tick(1);
    checkOutput("t5_newStrobe", 32'(bus.sampleReady), 32'd1);
    checkOutput("t5_newData", 32'(bus.sampleOut), 32'h5A5A);
    checkOutput("t5_count", samplesIssued, 32'd1);
    tick(300);

    // Push and pop together at fillLevel 3, write pointer wrapping to slot 0
    enable = 1'b0;
    clearLogs();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 16'(16'h6000 + i));
    enable = 1'b1;
    k = cycle;
    waitUntil(k + 1005);
    checkOutput("t6_inIssue", 32'(bus.sampleReady), 32'd1);
    checkOutput("t6_levelBefore", 32'(fillLevel), 32'd3);
    applyStimulus(1'b1, 16'h6007);
    checkOutput("t6_levelAfter", 32'(fillLevel), 32'd3);
    waitUntil(k + 2058);
    checkOutput("t6_strobeCount", 32'(strobeData.size()), 32'd8);
    if (strobeData.size() >= 8) begin
      bad = 0;
      for (int i = 0; i < 8; i++)
        if (strobeData[i] !== 16'(16'h6000 + i)) bad++;
      checkOutput("t6_wrapOrder", 32'(bad), 32'd0);
    end
    checkOutput("t6_samplesIssued", samplesIssued, 32'd9);
    checkOutput("t6_drained", 32'(fillLevel), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
